// File: rtl/ibus_sram_arbiter_if.sv
// Bus bundle between the two instruction-SRAM requesters, the arbiter and the SRAM macro.
// The slave modport is the arbiter's view; the master modport is the requester/SRAM side.
interface ibus_sram_arbiter_if #(
    parameter int unsigned SRAM_ADDR_WIDTH = 13,
    parameter int unsigned SRAM_DATA_WIDTH = 32
);
    localparam int unsigned AW = SRAM_ADDR_WIDTH - 2;

    logic                       req_0;
    logic [3:0]                 wen_0;
    logic [AW-1:0]              addr_0;
    logic [SRAM_DATA_WIDTH-1:0] wdata_0;
    logic                       gnt_0;
    logic                       rvalid_0;
    logic [SRAM_DATA_WIDTH-1:0] rdata_0;

    logic                       req_1;
    logic [3:0]                 wen_1;
    logic [AW-1:0]              addr_1;
    logic [SRAM_DATA_WIDTH-1:0] wdata_1;
    logic                       gnt_1;
    logic                       rvalid_1;
    logic [SRAM_DATA_WIDTH-1:0] rdata_1;

    logic                       mem_cen;
    logic [3:0]                 mem_wen;
    logic [AW-1:0]              mem_addr;
    logic [SRAM_DATA_WIDTH-1:0] mem_wdata;
    logic [SRAM_DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  req_0, wen_0, addr_0, wdata_0,
        input  req_1, wen_1, addr_1, wdata_1,
        input  mem_rdata,
        output gnt_0, rvalid_0, rdata_0,
        output gnt_1, rvalid_1, rdata_1,
        output mem_cen, mem_wen, mem_addr, mem_wdata
    );

    modport master (
        output req_0, wen_0, addr_0, wdata_0,
        output req_1, wen_1, addr_1, wdata_1,
        output mem_rdata,
        input  gnt_0, rvalid_0, rdata_0,
        input  gnt_1, rvalid_1, rdata_1,
        input  mem_cen, mem_wen, mem_addr, mem_wdata
    );
endinterface

// File: rtl/ibus_sram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port instruction SRAM, with a per-owner
// burst limit, posted single-cycle writes and one-cycle read return.
module ibus_sram_arbiter #(
    parameter int unsigned SRAM_ADDR_WIDTH = 13,
    parameter int unsigned SRAM_DATA_WIDTH = 32,
    parameter int unsigned MAX_BURST       = 4
) (
    input logic                HCLK,
    input logic                HRESETn,
    ibus_sram_arbiter_if.slave bus
);
    localparam logic [3:0] MaxBurst = 4'(MAX_BURST);

    logic       prev_gnt_q, prev_gnt_d;
    logic       last_q, last_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] rd_pend_q, rd_pend_d;

    logic gnt0, gnt1, gnt_any, sel;

    // Grant decision; gated by reset so nothing reaches the SRAM while HRESETn is low.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        sel  = 1'b0;
        if (HRESETn) begin
            unique case ({bus.req_1, bus.req_0})
                2'b01: gnt0 = 1'b1;
                2'b10: gnt1 = 1'b1;
                2'b11: begin
                    sel  = (prev_gnt_q && (cnt_q < MaxBurst)) ? last_q : ~last_q;
                    gnt0 = ~sel;
                    gnt1 = sel;
                end
                default: ;
            endcase
        end
    end

    assign gnt_any = gnt0 | gnt1;

    always_comb begin
        prev_gnt_d = prev_gnt_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        if (gnt_any) begin
            prev_gnt_d = 1'b1;
            if (prev_gnt_q && (last_q == gnt1)) begin
                // Saturate rather than wrap so a long solo stream still yields on contention.
                cnt_d = (cnt_q >= MaxBurst) ? MaxBurst : cnt_q + 4'd1;
            end else begin
                cnt_d  = 4'd1;
                last_d = gnt1;
            end
        end else begin
            prev_gnt_d = 1'b0;
            cnt_d      = 4'd0;
        end
        rd_pend_d = {gnt1 & (bus.wen_1 == 4'hF), gnt0 & (bus.wen_0 == 4'hF)};
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            prev_gnt_q <= 1'b0;
            last_q     <= 1'b1;
            cnt_q      <= 4'd0;
            rd_pend_q  <= 2'b00;
        end else begin
            prev_gnt_q <= prev_gnt_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            rd_pend_q  <= rd_pend_d;
        end
    end

    always_comb begin
        bus.gnt_0     = gnt0;
        bus.gnt_1     = gnt1;
        bus.mem_cen   = ~gnt_any;
        bus.mem_wen   = gnt1 ? bus.wen_1 : (gnt0 ? bus.wen_0 : 4'hF);
        bus.mem_addr  = gnt1 ? bus.addr_1 : bus.addr_0;
        bus.mem_wdata = gnt1 ? bus.wdata_1 : bus.wdata_0;
        bus.rvalid_0  = rd_pend_q[0] & HRESETn;
        bus.rvalid_1  = rd_pend_q[1] & HRESETn;
        bus.rdata_0   = bus.mem_rdata;
        bus.rdata_1   = bus.mem_rdata;
    end
endmodule

// File: tb/tb_ibus_sram_arbiter.sv
// Directed and randomized checks of ibus_sram_arbiter against a transaction-level model
// of the arbitration rules and an independent copy of SRAM contents.
module tb_ibus_sram_arbiter;
    localparam int unsigned AW_B  = 13;
    localparam int unsigned DW    = 32;
    localparam int          MAXB  = 4;
    localparam int          WORDS = 1 << (AW_B - 2);

    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    always #5 HCLK = ~HCLK;

    ibus_sram_arbiter_if #(.SRAM_ADDR_WIDTH(AW_B), .SRAM_DATA_WIDTH(DW)) bus ();

    ibus_sram_arbiter #(
        .SRAM_ADDR_WIDTH(AW_B),
        .SRAM_DATA_WIDTH(DW),
        .MAX_BURST      (MAXB)
    ) dut (
        .HCLK   (HCLK),
        .HRESETn(HRESETn),
        .bus    (bus)
    );

    // Behavioural SRAM macro driven by the DUT's mem_* outputs.
    logic [DW-1:0] sram [WORDS];
    always @(posedge HCLK) begin
        if (bus.mem_cen === 1'b0) begin
            if (bus.mem_wen == 4'hF) bus.mem_rdata <= sram[bus.mem_addr];
            else
                for (int b = 0; b < 4; b++)
                    if (!bus.mem_wen[b]) sram[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
        end
    end

    // Reference model: expected memory image plus who-owns-the-stream bookkeeping.
    logic [DW-1:0] ref_mem [WORDS];
    int            tests = 0;
    int            fails = 0;
    bit            m_had;
    int            m_owner;
    int            m_streak;
    int            m_rd_port;
    logic [DW-1:0] m_rd_data;
    int            wait0, wait1;
    bit            got0, got1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_had = 1'b0; m_owner = 1; m_streak = 0; m_rd_port = -1;
        wait0 = 0; wait1 = 0;
    endtask

    // One clock cycle: inputs already applied; check at negedge, then advance the model.
    task automatic run_cycle();
        int            g;
        logic [3:0]    w;
        logic [10:0]   a;
        logic [DW-1:0] d;
        @(negedge HCLK);
        g = -1;
        if (HRESETn) begin
            if (bus.req_0 && !bus.req_1) g = 0;
            else if (bus.req_1 && !bus.req_0) g = 1;
            else if (bus.req_0 && bus.req_1)
                g = (m_had && m_streak < MAXB) ? m_owner : 1 - m_owner;
        end
        w = (g == 1) ? bus.wen_1 : bus.wen_0;
        a = (g == 1) ? bus.addr_1 : bus.addr_0;
        d = (g == 1) ? bus.wdata_1 : bus.wdata_0;
        check("gnt_0", bus.gnt_0, g == 0);
        check("gnt_1", bus.gnt_1, g == 1);
        check("mem_cen", bus.mem_cen, g < 0);
        check("mem_wen", bus.mem_wen, (g < 0) ? 4'hF : w);
        check("rvalid_0", bus.rvalid_0, HRESETn && m_rd_port == 0);
        check("rvalid_1", bus.rvalid_1, HRESETn && m_rd_port == 1);
        if (HRESETn && m_rd_port == 0) check("rdata_0", bus.rdata_0, m_rd_data);
        if (HRESETn && m_rd_port == 1) check("rdata_1", bus.rdata_1, m_rd_data);
        if (g >= 0) begin
            check("mem_addr", 32'(bus.mem_addr), 32'(a));
            if (w != 4'hF) check("mem_wdata", bus.mem_wdata, d);
        end
        got0 = (g == 0);
        got1 = (g == 1);
        if (!HRESETn) begin
            model_reset();
        end else begin
            wait0 = (bus.req_0 && g != 0) ? wait0 + 1 : 0;
            wait1 = (bus.req_1 && g != 1) ? wait1 + 1 : 0;
            if (wait0 > 0) check("wait_0", wait0 <= MAXB, 1);
            if (wait1 > 0) check("wait_1", wait1 <= MAXB, 1);
            m_rd_port = -1;
            if (g >= 0) begin
                if (w == 4'hF) begin
                    m_rd_port = g;
                    m_rd_data = ref_mem[a];
                end else begin
                    for (int b = 0; b < 4; b++)
                        if (!w[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
                end
                if (m_had && m_owner == g) m_streak = (m_streak < MAXB) ? m_streak + 1 : MAXB;
                else begin
                    m_streak = 1;
                    m_owner  = g;
                end
                m_had = 1'b1;
            end else begin
                m_had = 1'b0;
                m_streak = 0;
            end
        end
        @(posedge HCLK);
        #1;
    endtask

    task automatic set_port(input int p, input bit r, input logic [3:0] w, input logic [10:0] a,
                            input logic [DW-1:0] d);
        if (p == 0) begin
            bus.req_0 = r; bus.wen_0 = w; bus.addr_0 = a; bus.wdata_0 = d;
        end else begin
            bus.req_1 = r; bus.wen_1 = w; bus.addr_1 = a; bus.wdata_1 = d;
        end
    endtask

    initial begin
        for (int i = 0; i < WORDS; i++) begin
            sram[i]    = $urandom;
            ref_mem[i] = sram[i];
        end
        sram[16]    = 32'hDEADBEEF;
        ref_mem[16] = 32'hDEADBEEF;
        bus.mem_rdata = '0;
        model_reset();
        // Requests during reset must be ignored.
        set_port(0, 1'b1, 4'hF, 11'h001, '0);
        set_port(1, 1'b1, 4'hF, 11'h002, '0);
        run_cycle();
        run_cycle();
        set_port(0, 1'b0, 4'hF, '0, '0);
        set_port(1, 1'b0, 4'hF, '0, '0);
        run_cycle();
        HRESETn = 1'b1;

        // Single read from port 0 of the preloaded word.
        set_port(0, 1'b1, 4'hF, 11'h010, '0);
        run_cycle();
        set_port(0, 1'b0, 4'hF, '0, '0);
        run_cycle();

        // Fresh reset, then continuous contention: port 0 first, bursts of MAX_BURST.
        HRESETn = 1'b0;
        run_cycle();
        HRESETn = 1'b1;
        for (int i = 0; i < 14; i++) begin
            set_port(0, 1'b1, 4'hF, 11'(i), '0);
            set_port(1, 1'b1, 4'hF, 11'(i + 100), '0);
            run_cycle();
        end
        set_port(0, 1'b0, 4'hF, '0, '0);
        set_port(1, 1'b0, 4'hF, '0, '0);
        run_cycle();

        // Partial write from port 1 then read back.
        set_port(1, 1'b1, 4'b1100, 11'h020, 32'h12345678);
        run_cycle();
        set_port(1, 1'b1, 4'hF, 11'h020, '0);
        run_cycle();
        set_port(1, 1'b0, 4'hF, '0, '0);
        run_cycle();

        // Reset right after a read grant drops the pending rvalid.
        set_port(0, 1'b1, 4'hF, 11'h005, '0);
        run_cycle();
        set_port(0, 1'b0, 4'hF, '0, '0);
        HRESETn = 1'b0;
        run_cycle();
        run_cycle();
        HRESETn = 1'b1;
        run_cycle();

        // Port 0 streams alone until its count saturates, then port 1 joins.
        for (int i = 0; i < 6; i++) begin
            set_port(0, 1'b1, 4'hF, 11'(i + 40), '0);
            run_cycle();
        end
        set_port(1, 1'b1, 4'hF, 11'h030, '0);
        run_cycle();
        set_port(0, 1'b0, 4'hF, '0, '0);
        set_port(1, 1'b0, 4'hF, '0, '0);
        run_cycle();

        // Randomized traffic; requests are held until granted.
        for (int i = 0; i < 600; i++) begin
            if (!bus.req_0 && $urandom_range(0, 2) != 0)
                set_port(0, 1'b1, ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom),
                         11'($urandom_range(0, 63)), $urandom);
            if (!bus.req_1 && $urandom_range(0, 2) != 0)
                set_port(1, 1'b1, ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom),
                         11'($urandom_range(0, 63)), $urandom);
            HRESETn = ($urandom_range(0, 99) != 0);
            run_cycle();
            if (got0) bus.req_0 = 1'b0;
            if (got1) bus.req_1 = 1'b0;
        end
        HRESETn = 1'b1;
        set_port(0, 1'b0, 4'hF, '0, '0);
        set_port(1, 1'b0, 4'hF, '0, '0);
        run_cycle();
        run_cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
